// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
// Optional subtract/overflow support: define NIBBLE_ADD_SUB_EN.
package nibble_serial_add_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int nnib_of(input int width);
    return width / NIBBLE_W;
  endfunction

  function automatic int idx_w_of(input int width);
    int n;
    n = nnib_of(width);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice.
// c3 is the carry into bit 3, exported for signed-overflow detection.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;

  assign p = x ^ y;
  assign g = x & y;

  assign c1 = g[0]
            | (p[0] & cin);

  assign c2 = g[1]
            | (p[1] & g[0])
            | (p[1] & p[0] & cin);

  assign c3 = g[2]
            | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin);

  assign cout = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder sharing one 4-bit lookahead slice.
// Define NIBBLE_ADD_SUB_EN to add the sub input and ovf output.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int NNIB = nnib_of(WIDTH);
  localparam int IW   = idx_w_of(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(NNIB - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [IW-1:0]    idx_q;
  logic             cy_q;
  logic             co_q;

  logic [3:0] xn;
  logic [3:0] yn;
  logic [3:0] sn;
  logic       cn;

  assign xn = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign yn = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

`ifdef NIBBLE_ADD_SUB_EN
  logic c3n;
  logic ovf_q;

  cla4_slice u_slice (
    .x    (xn),
    .y    (yn),
    .cin  (cy_q),
    .s    (sn),
    .cout (cn),
    .c3   (c3n)
  );

  assign ovf = ovf_q;
`else
  cla4_slice u_slice (
    .x    (xn),
    .y    (yn),
    .cin  (cy_q),
    .s    (sn),
    .cout (cn),
    .c3   ()
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      idx_q <= '0;
      cy_q  <= 1'b0;
      co_q  <= 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            idx_q <= '0;
            sum_q <= '0;
`ifdef NIBBLE_ADD_SUB_EN
            b_q   <= sub ? ~b : b;
            cy_q  <= sub ? 1'b1 : ci;
`else
            b_q   <= b;
            cy_q  <= ci;
`endif
          end
        end
        RUN: begin
          sum_q[idx_q*NIBBLE_W +: NIBBLE_W] <= sn;
          cy_q  <= cn;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            co_q  <= cn;
`ifdef NIBBLE_ADD_SUB_EN
            ovf_q <= c3n ^ cn;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign sum = sum_q;
  assign co  = co_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl (WIDTH=16).
// Sub/ovf checks compile in when NIBBLE_ADD_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;
`ifdef NIBBLE_ADD_SUB_EN
  logic         sub;
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
`ifdef NIBBLE_ADD_SUB_EN
    .sub   (sub),
    .ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic c, input logic s);
    exp_t         e;
    logic [W-1:0] yy;
    logic         cc;
    logic [W:0]   r;
    yy  = s ? ~y : y;
    cc  = s ? 1'b1 : c;
    r   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    e.s = r[W-1:0];
    e.c = r[W];
    e.v = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result();
    exp_t e;
    if (q.size() == 0) begin
      chk("sb_empty", 32'(q.size()), 32'd1);
    end else begin
      e = q.pop_front();
      chk("sum", 32'(sum), 32'(e.s));
      chk("co", 32'(co), 32'(e.c));
`ifdef NIBBLE_ADD_SUB_EN
      chk("ovf", 32'(ovf), 32'(e.v));
`endif
    end
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic s);
    a  = x;
    b  = y;
    ci = c;
`ifdef NIBBLE_ADD_SUB_EN
    sub = s;
`endif
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic s);
    int cyc;
    drive(x, y, c, s);
    start = 1'b1;
    q.push_back(model(x, y, c, s));
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      chk("done_timeout", 32'(done), 32'd1);
    end else begin
      chk("latency", 32'(cyc), 32'd5);
      check_result();
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int   cyc;
    int   ph;
    logic s;
    rst_n = 1'b0;
    start = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);

    // start and operand churn during RUN must be ignored
    drive(16'h00FF, 16'h0001, 1'b0, 1'b0);
    start = 1'b1;
    q.push_back(model(16'h00FF, 16'h0001, 1'b0, 1'b0));
    @(negedge clk);
    drive(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!done) drive(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    end
    if (!done) begin
      chk("ign_timeout", 32'(done), 32'd1);
    end else begin
      chk("ign_latency", 32'(cyc), 32'd5);
      check_result();
    end
    @(negedge clk);
    chk("no_accept_in_done", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);

    // reset in the second RUN cycle drops the op
    drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_sum", 32'(sum), 32'd0);
    chk("mr_co", 32'(co), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mr_no_done", 32'(done), 32'd0);
    end
    run_op(16'h1111, 16'h2222, 1'b1, 1'b0);

`ifdef NIBBLE_ADD_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
`endif

    // start held high: one accept every 6 cycles
    ph = 0;
    for (int i = 0; i < 24; i++) begin
      chk("b2b_busy", 32'(busy), 32'(ph != 0));
      chk("b2b_done", 32'(done), 32'(ph == 5));
      if (done) check_result();
      start = (i < 19);
      s = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
      s = 1'($urandom);
`endif
      drive(16'($urandom), 16'($urandom), 1'($urandom), s);
      if (ph == 0 && start) q.push_back(model(a, b, ci, s));
      ph = (ph + 1) % 6;
      @(negedge clk);
    end
    start = 1'b0;
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
